// File: rtl/sid_mix_pkg.sv
// Shared types and width helpers for the SID output mixer and related audio stages.
package sid_mix_pkg;

  // Master volume is a 4-bit linear gain, so scaling by vol is undone by this shift.
  localparam int VOL_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    SAT   = 2'd3
  } mix_state_e;

  // Sum of nch signed vw-bit samples cannot overflow this width.
  function automatic int sum_width(input int vw, input int nch);
    return vw + $clog2(nch);
  endfunction

  // Product of the channel sum and a zero-extended 4-bit volume.
  function automatic int prod_width(input int vw, input int nch);
    return sum_width(vw, nch) + 5;
  endfunction

endpackage

// File: rtl/sid_audio_mixer_if.sv
// Frame input and DAC-side output bundle for the SID mixer.
// A frame transfers on the rising clk edge where in_valid && in_ready; ch_in/ch_en/vol
// only need to be valid on that edge. out_valid is a one-cycle pulse and out_sample /
// out_clip hold their values until the next pulse (there is no backpressure on the output).
interface sid_audio_mixer_if #(
  parameter int NCH = 4,
  parameter int VW  = 16,
  parameter int N   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [NCH*VW-1:0]  ch_in;
  logic [NCH-1:0]     ch_en;
  logic [3:0]         vol;
  logic [N-1:0]       out_sample;
  logic               out_valid;
  logic               out_clip;

  modport slave (
    input  in_valid, ch_in, ch_en, vol,
    output in_ready, out_sample, out_valid, out_clip
  );

  modport master (
    output in_valid, ch_in, ch_en, vol,
    input  in_ready, out_sample, out_valid, out_clip
  );
endinterface

// File: rtl/sat_to_offset.sv
// Saturate a signed value to N bits and convert it to unsigned offset binary.
// Narrower inputs are sign-extended and can never clip.
module sat_to_offset #(
  parameter int IW = 23,
  parameter int N  = 16
) (
  input  logic signed [IW-1:0] din,
  output logic [N-1:0]         dout,
  output logic                 clip
);

  logic signed [N-1:0] sat;

  generate
    if (IW > N) begin : g_sat
      logic in_range;
      // In range when every bit above the output sign bit copies the input sign.
      assign in_range = (din[IW-1:N-1] == {(IW-N+1){din[IW-1]}});

      always_comb begin
        clip = ~in_range;
        if (in_range) begin
          sat = din[N-1:0];
        end else if (din[IW-1]) begin
          sat = {1'b1, {(N-1){1'b0}}};
        end else begin
          sat = {1'b0, {(N-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign sat  = N'(din);
      assign clip = 1'b0;
    end
  endgenerate

  assign dout = {~sat[N-1], sat[N-2:0]};

endmodule

// File: rtl/sid_audio_mixer.sv
// Final SID mixing stage: masked channel sum, master volume, saturation to offset binary.
// One adder and one multiplier are shared across the frame under a small FSM.
module sid_audio_mixer
  import sid_mix_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int VW         = 16,
  parameter int N          = 16,
  parameter int GAIN_SHIFT = 2
) (
  input  logic               clk,
  input  logic               n_reset,
  sid_audio_mixer_if.slave   bus,
  output mix_state_e         dbg_state
);

  localparam int SW   = sum_width(VW, NCH);
  localparam int PW   = prod_width(VW, NCH);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RSH  = VOL_SHIFT + GAIN_SHIFT;

  mix_state_e             state, state_nx;
  logic [IDXW-1:0]        idx;
  logic signed [SW-1:0]   acc;
  logic signed [SW-1:0]   addend;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   shifted;
  logic [NCH*VW-1:0]      cap_ch;
  logic [NCH-1:0]         cap_en;
  logic [3:0]             cap_vol;
  logic                   accept;
  logic                   last_ch;
  logic [N-1:0]           sat_sample;
  logic                   sat_clip;
  logic [N-1:0]           out_sample_q;
  logic                   out_valid_q;
  logic                   out_clip_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last_ch  = (idx == IDXW'(NCH - 1));
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = ACC;
        end
      end
      ACC:     if (last_ch) state_nx = SCALE;
      SCALE:   state_nx = SAT;
      SAT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Masked channels feed zero into the shared adder rather than being skipped.
  always_comb begin
    addend = '0;
    if (cap_en[idx]) begin
      addend = SW'($signed(cap_ch[idx*VW +: VW]));
    end
  end

  assign shifted = prod >>> RSH;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      idx          <= '0;
      acc          <= '0;
      prod         <= '0;
      cap_ch       <= '0;
      cap_en       <= '0;
      cap_vol      <= '0;
      out_sample_q <= {1'b1, {(N-1){1'b0}}};
      out_valid_q  <= 1'b0;
      out_clip_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_ch  <= bus.ch_in;
            cap_en  <= bus.ch_en;
            cap_vol <= bus.vol;
            acc     <= '0;
            idx     <= '0;
          end
        end
        ACC: begin
          acc <= acc + addend;
          idx <= idx + IDXW'(1);
        end
        SCALE: begin
          prod <= PW'(acc) * PW'($signed({1'b0, cap_vol}));
        end
        SAT: begin
          out_sample_q <= sat_sample;
          out_clip_q   <= sat_clip;
          out_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_to_offset #(
    .IW (PW),
    .N  (N)
  ) u_sat (
    .din  (shifted),
    .dout (sat_sample),
    .clip (sat_clip)
  );

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_clip   = out_clip_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_sid_audio_mixer.sv
// Self-checking bench for sid_audio_mixer: two instances (GAIN_SHIFT 2 and 0) driven in lockstep.
module tb_sid_audio_mixer;
  import sid_mix_pkg::*;

  localparam int NCH = 4;
  localparam int VW  = 16;
  localparam int N   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic              drv_valid = 1'b0;
  logic [NCH*VW-1:0] drv_ch    = '0;
  logic [NCH-1:0]    drv_en    = '0;
  logic [3:0]        drv_vol   = '0;

  sid_audio_mixer_if #(.NCH(NCH), .VW(VW), .N(N)) bus2 ();
  sid_audio_mixer_if #(.NCH(NCH), .VW(VW), .N(N)) bus0 ();

  assign bus2.in_valid = drv_valid;
  assign bus2.ch_in    = drv_ch;
  assign bus2.ch_en    = drv_en;
  assign bus2.vol      = drv_vol;
  assign bus0.in_valid = drv_valid;
  assign bus0.ch_in    = drv_ch;
  assign bus0.ch_en    = drv_en;
  assign bus0.vol      = drv_vol;

  mix_state_e dbg2, dbg0;

  sid_audio_mixer #(.NCH(NCH), .VW(VW), .N(N), .GAIN_SHIFT(2)) u_dut_g2 (
    .clk(clk), .n_reset(n_reset), .bus(bus2.slave), .dbg_state(dbg2)
  );
  sid_audio_mixer #(.NCH(NCH), .VW(VW), .N(N), .GAIN_SHIFT(0)) u_dut_g0 (
    .clk(clk), .n_reset(n_reset), .bus(bus0.slave), .dbg_state(dbg0)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q2[$];
  logic [16:0] exp_q0[$];

  // Reference: {clip, offset-binary sample} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [63:0] ch, input logic [3:0] en,
                                        input logic [3:0] v, input int gs);
    longint sum, p, r;
    logic [15:0] s;
    sum = 0;
    for (int k = 0; k < NCH; k++) begin
      if (en[k]) begin
        s = ch[k*16 +: 16];
        sum += longint'($signed(s));
      end
    end
    p = sum * longint'(v);
    r = p >>> (4 + gs);
    if (r > 32767)  return {1'b1, 16'hFFFF};
    if (r < -32768) return {1'b1, 16'h0000};
    return {1'b0, 16'(r + 32768)};
  endfunction

  function automatic logic [63:0] rand_frame();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < NCH; k++) begin
      case ($urandom_range(0, 3))
        0:       f[k*16 +: 16] = 16'h8000;
        1:       f[k*16 +: 16] = 16'h7FFF;
        default: f[k*16 +: 16] = 16'($urandom);
      endcase
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_frame(input logic [63:0] ch, input logic [3:0] en, input logic [3:0] v);
    drv_ch  = ch;
    drv_en  = en;
    drv_vol = v;
  endtask

  // Presents a frame, waits (bounded) for the accept edge, then scrambles the inputs.
  // Returns at the falling edge just after the accept edge.
  task automatic send_frame(input logic [63:0] ch, input logic [3:0] en,
                            input logic [3:0] v, output bit ok);
    @(negedge clk);
    set_frame(ch, en, v);
    drv_valid = 1'b1;
    for (int n = 0; n < 20 && !bus2.in_ready; n++) @(negedge clk);
    ok = bus2.in_ready;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    set_frame(rand_frame(), 4'($urandom), 4'($urandom));
  endtask

  // Edges from accept to out_valid, or -1 if it never appears.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus2.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_reset = 1'b0;
    drv_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus2.out_sample !== 16'h8000) begin n_fail++; $display("FAIL reset_sample: got %h expected 8000", bus2.out_sample); end
    n_checks++; if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus2.in_ready); end
    n_checks++; if (bus2.out_valid !== 1'b0 || bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b/%b expected 0/0", bus2.out_valid, bus0.out_valid); end
    n_checks++; if (bus2.out_clip !== 1'b0 || bus0.out_clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip: got %b/%b expected 0/0", bus2.out_clip, bus0.out_clip); end
    n_checks++; if (dbg2 !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg2, IDLE); end
    n_reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus0.out_sample !== 16'h8000 || bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset: got %h/%b expected 8000/1", bus0.out_sample, bus0.in_ready); end
  endtask

  task automatic test_single_channel();
    bit ok; int lat;
    send_frame(64'h0000_0000_0000_4000, 4'b1111, 4'd15, ok);
    wait_out(lat);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", ok); end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL single_latency: got %0d expected 6", lat); end
    n_checks++; if ({bus2.out_clip, bus2.out_sample} !== {1'b0, 16'h8F00}) begin n_fail++; $display("FAIL single_g2: got %b/%h expected 0/8f00", bus2.out_clip, bus2.out_sample); end
    n_checks++; if ({bus0.out_clip, bus0.out_sample} !== {1'b0, 16'hBC00}) begin n_fail++; $display("FAIL single_g0: got %b/%h expected 0/bc00", bus0.out_clip, bus0.out_sample); end
    @(negedge clk);
    n_checks++; if (bus2.out_valid !== 1'b0 || bus2.out_sample !== 16'h8F00) begin n_fail++; $display("FAIL single_hold: got %b/%h expected 0/8f00", bus2.out_valid, bus2.out_sample); end
  endtask

  task automatic test_saturation();
    bit ok; int lat;
    send_frame({4{16'h8000}}, 4'b1111, 4'd15, ok);
    wait_out(lat);
    n_checks++; if ({bus0.out_clip, bus0.out_sample} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL sat_neg_g0: got %b/%h expected 1/0000", bus0.out_clip, bus0.out_sample); end
    n_checks++; if ({bus2.out_clip, bus2.out_sample} !== {1'b0, 16'h0800}) begin n_fail++; $display("FAIL sat_neg_g2: got %b/%h expected 0/0800", bus2.out_clip, bus2.out_sample); end
    send_frame({4{16'h7FFF}}, 4'b1111, 4'd15, ok);
    wait_out(lat);
    n_checks++; if ({bus0.out_clip, bus0.out_sample} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL sat_pos_g0: got %b/%h expected 1/ffff", bus0.out_clip, bus0.out_sample); end
    n_checks++; if ({bus2.out_clip, bus2.out_sample} !== {1'b0, 16'hF7FF}) begin n_fail++; $display("FAIL sat_pos_g2: got %b/%h expected 0/f7ff", bus2.out_clip, bus2.out_sample); end
  endtask

  task automatic test_mask_volume();
    bit ok; int lat;
    send_frame(64'h0000_0000_1000_1000, 4'b0001, 4'd8, ok);
    wait_out(lat);
    n_checks++; if ({bus2.out_clip, bus2.out_sample} !== {1'b0, 16'h8200}) begin n_fail++; $display("FAIL mask_g2: got %b/%h expected 0/8200", bus2.out_clip, bus2.out_sample); end
    n_checks++; if ({bus0.out_clip, bus0.out_sample} !== {1'b0, 16'h8800}) begin n_fail++; $display("FAIL mask_g0: got %b/%h expected 0/8800", bus0.out_clip, bus0.out_sample); end
    send_frame(64'h0000_0000_1000_1000, 4'b0001, 4'd0, ok);
    wait_out(lat);
    n_checks++; if ({bus2.out_clip, bus2.out_sample} !== {1'b0, 16'h8000}) begin n_fail++; $display("FAIL vol0_g2: got %b/%h expected 0/8000", bus2.out_clip, bus2.out_sample); end
    send_frame({4{16'h7FFF}}, 4'b0000, 4'd15, ok);
    wait_out(lat);
    n_checks++; if ({bus0.out_clip, bus0.out_sample} !== {1'b0, 16'h8000}) begin n_fail++; $display("FAIL masked_g0: got %b/%h expected 0/8000", bus0.out_clip, bus0.out_sample); end
  endtask

  task automatic test_random();
    bit ok; int lat;
    logic [63:0] ch; logic [3:0] en, v;
    logic [16:0] e2, e0;
    for (int f = 0; f < 16; f++) begin
      ch = rand_frame();
      en = 4'($urandom);
      v  = 4'($urandom);
      e2 = model(ch, en, v, 2);
      e0 = model(ch, en, v, 0);
      send_frame(ch, en, v, ok);
      wait_out(lat);
      n_checks++; if (lat != 6) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 6", f, lat); end
      n_checks++; if ({bus2.out_clip, bus2.out_sample} !== e2) begin n_fail++; $display("FAIL rand_g2[%0d]: got %h expected %h", f, {bus2.out_clip, bus2.out_sample}, e2); end
      n_checks++; if ({bus0.out_clip, bus0.out_sample} !== e0) begin n_fail++; $display("FAIL rand_g0[%0d]: got %h expected %h", f, {bus0.out_clip, bus0.out_sample}, e0); end
    end
  endtask

  task automatic test_back_to_back();
    int prev_acc; int n_acc;
    logic [15:0] last2;
    logic [16:0] e;
    exp_q2.delete();
    exp_q0.delete();
    prev_acc = -1;
    n_acc = 0;
    @(negedge clk);
    last2 = bus2.out_sample;
    drv_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      if (bus2.out_valid) begin
        n_checks++;
        if (exp_q2.size() == 0 || exp_q0.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_out: got pulse at t=%0d expected none", t);
        end else begin
          e = exp_q2.pop_front();
          if ({bus2.out_clip, bus2.out_sample} !== e) begin n_fail++; $display("FAIL b2b_g2: got %h expected %h", {bus2.out_clip, bus2.out_sample}, e); end
          n_checks++;
          e = exp_q0.pop_front();
          if ({bus0.out_clip, bus0.out_sample} !== e) begin n_fail++; $display("FAIL b2b_g0: got %h expected %h", {bus0.out_clip, bus0.out_sample}, e); end
        end
      end else begin
        n_checks++;
        if (bus2.out_sample !== last2) begin n_fail++; $display("FAIL b2b_hold: got %h expected %h", bus2.out_sample, last2); end
      end
      last2 = bus2.out_sample;
      if (t >= 43) drv_valid = 1'b0;
      set_frame(rand_frame(), 4'($urandom), 4'($urandom));
      if (drv_valid && bus2.in_ready) begin
        exp_q2.push_back(model(drv_ch, drv_en, drv_vol, 2));
        exp_q0.push_back(model(drv_ch, drv_en, drv_vol, 0));
        if (prev_acc >= 0) begin
          n_checks++;
          if (t - prev_acc != 7) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 7", t - prev_acc); end
        end
        prev_acc = t;
        n_acc++;
      end
    end
    drv_valid = 1'b0;
    n_checks++; if (n_acc != 7) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 7", n_acc); end
    n_checks++; if (exp_q2.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q2.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int lat; int pulses;
    send_frame({4{16'h7FFF}}, 4'b1111, 4'd15, ok);
    wait_out(lat);
    n_checks++; if ({bus0.out_clip, bus0.out_sample} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL pre_reset_g0: got %b/%h expected 1/ffff", bus0.out_clip, bus0.out_sample); end
    send_frame(64'h0000_0000_0000_4000, 4'b1111, 4'd15, ok);
    repeat (3) @(negedge clk);
    n_reset = 1'b0;
    #1;
    n_checks++; if (bus2.out_sample !== 16'h8000 || bus0.out_sample !== 16'h8000) begin n_fail++; $display("FAIL mid_reset_sample: got %h/%h expected 8000/8000", bus2.out_sample, bus0.out_sample); end
    n_checks++; if (bus0.out_clip !== 1'b0 || bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_clip_ready: got %b/%b expected 0/1", bus0.out_clip, bus2.in_ready); end
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus2.out_valid || bus0.out_valid) pulses++;
    end
    n_reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus2.in_ready !== 1'b1 || dbg2 !== IDLE) begin n_fail++; $display("FAIL release_ready: got %b/%0d expected 1/%0d", bus2.in_ready, dbg2, IDLE); end
    repeat (8) begin
      @(negedge clk);
      if (bus2.out_valid || bus0.out_valid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_pulse: got %0d pulses expected 0", pulses); end
    send_frame(64'h0000_0000_1000_1000, 4'b0001, 4'd8, ok);
    wait_out(lat);
    n_checks++; if (lat != 6 || bus2.out_sample !== 16'h8200) begin n_fail++; $display("FAIL after_reset: got lat %0d sample %h expected 6/8200", lat, bus2.out_sample); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_channel();
    test_saturation();
    test_mask_volume();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
